adc045_avg: RTL

//  Decimating averager directly downstream of the adc045 ADC reader. Consumes the 24-bit

---
 rtl/adc045_avg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/adc045_avg.sv
// Decimating averager for the adc045 sample stream: per-channel mean of 2**LOG2_N samples,
// emitted through a 2-entry valid/ready queue with overrun detection.
module adc045_avg #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_channel,
  input  logic                     in_valid,
  input  logic                     clear,
  output logic        [DATA_W-1:0] out_data,
  output logic                     out_channel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun,
  output logic                     overrun_flag
);

  localparam int AW = DATA_W + LOG2_N;
  localparam int CW = (LOG2_N == 0) ? 1 : LOG2_N;
  // With LOG2_N=0 the 1-bit counter stays at 0, so every sample completes.
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << LOG2_N) - 1);

  typedef enum logic [1:0] {Q_EMPTY, Q_ONE, Q_FULL} q_state_t;

  logic signed [AW-1:0] r_acc [2];
  logic        [CW-1:0] r_cnt [2];

  q_state_t          r_state, w_next;
  logic [DATA_W-1:0] r_head_data, r_q1_data;
  logic              r_head_ch, r_q1_ch;
  logic              r_overrun, r_flag;

  logic signed [AW-1:0] w_sum;
  logic [DATA_W-1:0]    w_result;
  logic                 w_last, w_push, w_pop;
  logic                 w_load_head, w_head_from_q1, w_load_q1, w_drop;

  always_comb begin
    w_sum    = r_acc[in_channel] + AW'(in_data);
    w_result = DATA_W'(w_sum >>> LOG2_N);
    w_last   = (r_cnt[in_channel] == CNT_MAX);
    w_push   = in_valid && w_last && !clear;
    w_pop    = (r_state != Q_EMPTY) && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned c = 0; c < 2; c++) begin
        r_acc[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else if (in_valid) begin
      if (w_last) begin
        r_acc[in_channel] <= '0;
        r_cnt[in_channel] <= '0;
      end else begin
        r_acc[in_channel] <= w_sum;
        r_cnt[in_channel] <= r_cnt[in_channel] + 1'b1;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_load_head    = 1'b0;
    w_head_from_q1 = 1'b0;
    w_load_q1      = 1'b0;
    w_drop         = 1'b0;
    case (r_state)
      Q_EMPTY: begin
        if (w_push) begin
          w_next      = Q_ONE;
          w_load_head = 1'b1;
        end
      end
      Q_ONE: begin
        if (w_push && w_pop) begin
          w_load_head = 1'b1;
        end else if (w_push) begin
          w_load_q1 = 1'b1;
          w_next    = Q_FULL;
        end else if (w_pop) begin
          w_next = Q_EMPTY;
        end
      end
      Q_FULL: begin
        if (w_pop) begin
          w_load_head    = 1'b1;
          w_head_from_q1 = 1'b1;
          if (w_push) w_load_q1 = 1'b1;
          else        w_next    = Q_ONE;
        end else if (w_push) begin
          w_drop = 1'b1;
        end
      end
      default: w_next = Q_EMPTY;
    endcase
    if (clear) begin
      w_next      = Q_EMPTY;
      w_load_head = 1'b0;
      w_load_q1   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= Q_EMPTY;
      r_head_data <= '0;
      r_head_ch   <= 1'b0;
      r_q1_data   <= '0;
      r_q1_ch     <= 1'b0;
      r_overrun   <= 1'b0;
      r_flag      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_head) begin
        r_head_data <= w_head_from_q1 ? r_q1_data : w_result;
        r_head_ch   <= w_head_from_q1 ? r_q1_ch   : in_channel;
      end
      if (w_load_q1) begin
        r_q1_data <= w_result;
        r_q1_ch   <= in_channel;
      end
      r_overrun <= w_drop;
      if (clear)       r_flag <= 1'b0;
      else if (w_drop) r_flag <= 1'b1;
    end
  end

  assign out_data     = r_head_data;
  assign out_channel  = r_head_ch;
  assign out_valid    = (r_state != Q_EMPTY);
  assign overrun      = r_overrun;
  assign overrun_flag = r_flag;

endmodule
